audio_capture: RTL and testbench
================================

AUDIO_CAPTURE -- requirements
Module: audio_capture

Interface
REQ-001 Parameter BUFFER_ADDR_BITS, default 9, byte address width of one buffer half (512 B = one SD block).
REQ-002 clk  in  1  system clock (200 MHz), all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 enable_i  in  1  capture enable, level.
REQ-005 mono_i  in  1  1 = store left channel only; 0 = store left+right.
REQ-006 aud_bclk_i  in  1  codec bit clock, asynchronous to clk.
REQ-007 aud_adclrck_i  in  1  codec ADC word clock, asynchronous; 0 = left slot.
REQ-008 aud_adcdat_i  in  1  codec ADC serial data, I2S format, MSB first.
REQ-009 buffer_addr_o  out  BUFFER_ADDR_BITS  byte address within the active half.
REQ-010 buffer_sel_o  out  1  half currently being written (RAM address MSB).
REQ-011 buffer_wren_o  out  1  RAM write strobe, one clk per byte.
REQ-012 buffer_data_o  out  8  RAM write data.
REQ-013 buffer_filled_o  out  1  the half opposite buffer_sel_o holds a complete block.
REQ-014 buffer_filled_ack_i  in  1  consumer releases the filled half, one-clk pulse.
REQ-015 overrun_o  out  1  sticky: a half completed while the previous one was unacknowledged.

Function
REQ-016 aud_bclk_i, aud_adclrck_i, aud_adcdat_i SHALL each pass a 2-FF synchronizer; a BCLK rise event is synced bclk=1 with its previous-clk value 0.
REQ-017 All serial sampling SHALL occur only on BCLK rise events; LRCK and DAT are sampled on the same event.
REQ-018 A slot start SHALL be detected when the LRCK sampled at a BCLK rise differs from the value sampled at the previous BCLK rise; the MSB SHALL be taken at the next BCLK rise.
REQ-019 Exactly 16 bits per slot SHALL be shifted; further bits in the slot are ignored until the next LRCK change.
REQ-020 FSM states: IDLE, SYNC, SHIFT, WR_LO, WR_HI, SKIP.
REQ-021 IDLE -> SYNC when enable_i=1; SYNC -> SHIFT on a slot start with new LRCK=0 (left); right-slot starts ignored in SYNC.
REQ-022 SHIFT -> WR_LO on the clk after the 16th bit is captured; WR_LO writes sample[7:0] at buffer_addr_o, WR_HI writes sample[15:8] at buffer_addr_o+1 on the next clk; buffer_addr_o increments after each write.
REQ-023 After WR_HI -> SKIP; SKIP -> SHIFT on next slot start; if mono_i=1 right-slot starts are ignored (stay in SKIP) and no right data is written.
REQ-024 Stereo byte order per frame SHALL be L_lo, L_hi, R_lo, R_hi (WAV 16-bit little-endian).
REQ-025 buffer_addr_o SHALL wrap from 2^BUFFER_ADDR_BITS-1 to 0; on the write of the last byte the half is complete.
REQ-026 On half completion with buffer_filled_o=0 or buffer_filled_ack_i=1 on that clk: buffer_sel_o toggles and buffer_filled_o=1 on the next clk.
REQ-027 On half completion with buffer_filled_o=1 and no ack on that clk: overrun_o=1, buffer_sel_o unchanged, same half overwritten from address 0.
REQ-028 buffer_filled_ack_i while buffer_filled_o=1 and no completion SHALL clear buffer_filled_o next clk; ack while buffer_filled_o=0 is ignored.
REQ-029 enable_i=0 in any state except WR_LO SHALL force IDLE next clk with buffer_addr_o=0 (partial half discarded); in WR_LO, WR_HI completes first; buffer_sel_o, buffer_filled_o, overrun_o unchanged.
REQ-030 buffer_wren_o SHALL be 1 only in WR_LO/WR_HI; buffer_data_o holds last written byte otherwise.

Reset
REQ-031 rst_n=0 at a clk edge SHALL set FSM=IDLE, buffer_addr_o=0, buffer_sel_o=0, buffer_wren_o=0, buffer_data_o=0, buffer_filled_o=0, overrun_o=0, bit counter and shift register 0, synchronizers 0.
REQ-032 Reset mid-write SHALL suppress any further wren pulse from the interrupted sample.

Verification
REQ-033 Stereo: enable, BCLK 3.072 MHz, 32 BCLK/slot, L=0x1234, R=0xABCD -> writes 0x34@0, 0x12@1, 0xCD@2, 0xAB@3, each wren one clk.
REQ-034 Mono: mono_i=1, L=0x8001, R=0x7FFF -> only 0x01, 0x80 written per frame; 256 frames (BITS=9) -> buffer_sel_o 0->1, buffer_filled_o=1.
REQ-035 Overrun: fill two halves with no ack -> overrun_o=1 at 2nd completion, buffer_sel_o stays 1, addr restarts 0.
REQ-036 Simultaneous ack and completion on same clk -> buffer_filled_o stays 1, buffer_sel_o toggles, overrun_o=0.
REQ-037 Enable raised mid right slot -> first write is next left sample; enable dropped mid-SHIFT -> no wren, addr=0.
REQ-038 rst_n=0 one clk after WR_LO -> no WR_HI strobe, all outputs at REQ-031 values.

Source files
------------

// File: rtl/audio_capture.sv
// I2S ADC capture into a double-buffered byte RAM.
// Each half holds one SD block; the consumer acknowledges filled halves.
module audio_capture #(
    parameter int BUFFER_ADDR_BITS = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    input  logic                        mono_i,
    input  logic                        aud_bclk_i,
    input  logic                        aud_adclrck_i,
    input  logic                        aud_adcdat_i,
    output logic [BUFFER_ADDR_BITS-1:0] buffer_addr_o,
    output logic                        buffer_sel_o,
    output logic                        buffer_wren_o,
    output logic [7:0]                  buffer_data_o,
    output logic                        buffer_filled_o,
    input  logic                        buffer_filled_ack_i,
    output logic                        overrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SHIFT,
        WR_LO,
        WR_HI,
        SKIP
    } state_t;

    localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_ONE =
        {{(BUFFER_ADDR_BITS-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_d;
    logic [1:0]  bclk_sync;
    logic [1:0]  lrck_sync;
    logic [1:0]  dat_sync;
    logic        bclk_prev;
    logic        lrck_last;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_q;
    logic [7:0]  last_byte;

    logic bclk_rise;
    logic slot_start;
    logic left_start;
    logic half_done;

    assign bclk_rise  = bclk_sync[1] & ~bclk_prev;
    assign slot_start = bclk_rise & (lrck_sync[1] != lrck_last);
    assign left_start = slot_start & ~lrck_sync[1];
    assign half_done  = buffer_wren_o & (&buffer_addr_o);

    // Bring the codec pins into clk and track LRCK as seen on BCLK rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrck_last <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], aud_bclk_i};
            lrck_sync <= {lrck_sync[0], aud_adclrck_i};
            dat_sync  <= {dat_sync[0], aud_adcdat_i};
            bclk_prev <= bclk_sync[1];
            if (bclk_rise) begin
                lrck_last <= lrck_sync[1];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, write strobe and write data.
    always_comb begin
        state_d       = state;
        buffer_wren_o = 1'b0;
        buffer_data_o = last_byte;
        unique case (state)
            IDLE: begin
                if (enable_i) state_d = SYNC;
            end
            SYNC: begin
                if (left_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == 5'd16) state_d = WR_LO;
            end
            WR_LO: begin
                state_d       = WR_HI;
                buffer_wren_o = 1'b1;
                buffer_data_o = shift_q[7:0];
            end
            WR_HI: begin
                state_d       = SKIP;
                buffer_wren_o = 1'b1;
                buffer_data_o = shift_q[15:8];
            end
            SKIP: begin
                if (left_start || (slot_start && !mono_i)) begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable_i && state != WR_LO) begin
            state_d = IDLE;
        end
    end

    // Shift in 16 bits per slot; later bits in the slot are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            last_byte <= '0;
        end else begin
            if (state != SHIFT) begin
                bit_cnt <= '0;
            end else if (bclk_rise && bit_cnt != 5'd16) begin
                shift_q <= {shift_q[14:0], dat_sync[1]};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (buffer_wren_o) begin
                last_byte <= buffer_data_o;
            end
        end
    end

    // Address walk and half ownership hand-off to the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer_addr_o   <= '0;
            buffer_sel_o    <= 1'b0;
            buffer_filled_o <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            if (!enable_i && state != WR_LO) begin
                buffer_addr_o <= '0;
            end else if (buffer_wren_o) begin
                buffer_addr_o <= buffer_addr_o + ADDR_ONE;
            end
            if (half_done) begin
                if (!buffer_filled_o || buffer_filled_ack_i) begin
                    buffer_sel_o    <= ~buffer_sel_o;
                    buffer_filled_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (buffer_filled_ack_i && buffer_filled_o) begin
                buffer_filled_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_capture.sv
// Bench for audio_capture: I2S frames with random samples
// checked against a byte-queue scoreboard and a buffer model.
module tb_audio_capture;

    localparam int AW   = 5;
    localparam int MAXA = (1 << AW) - 1;
    localparam int H    = 37;
    localparam int SLOT = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          mono;
    logic          bclk;
    logic          lrck;
    logic          dat;
    logic [AW-1:0] addr;
    logic          sel;
    logic          wren;
    logic [7:0]    data;
    logic          filled;
    logic          ack;
    logic          overrun;

    audio_capture #(.BUFFER_ADDR_BITS(AW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_i            (enable),
        .mono_i              (mono),
        .aud_bclk_i          (bclk),
        .aud_adclrck_i       (lrck),
        .aud_adcdat_i        (dat),
        .buffer_addr_o       (addr),
        .buffer_sel_o        (sel),
        .buffer_wren_o       (wren),
        .buffer_data_o       (data),
        .buffer_filled_o     (filled),
        .buffer_filled_ack_i (ack),
        .overrun_o           (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    int         m_addr;
    logic       m_sel;
    logic       m_filled;
    logic       m_over;
    logic [7:0] m_last;
    logic       mon_on;
    logic       cap;
    int         ack_mode;
    logic       rst_at_wrlo;
    logic       rst_rel;
    logic [7:0] exp_b;
    logic       cmpl;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One I2S frame: left slot then right slot, MSB one BCLK after LRCK edge.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int mode);
        logic [15:0] w;
        for (int s = 0; s < 2; s++) begin
            w = (s == 0) ? l : r;
            for (int i = 0; i < SLOT; i++) begin
                bclk = 1'b0;
                lrck = s[0];
                dat  = (i >= 1 && i <= 16) ? w[16-i] : 1'($urandom);
                if (i == 0 && cap && (s == 0 || !mono)) begin
                    q.push_back(w[7:0]);
                    q.push_back(w[15:8]);
                end
                if (mode == 1 && s == 1 && i == 5) begin
                    @(posedge clk);
                    #1 enable = 1'b1;
                end
                if (mode == 2 && s == 0 && i == 8) begin
                    @(posedge clk);
                    #1 enable = 1'b0;
                end
                #H bclk = 1'b1;
                #H;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_addr"}, addr, 0);
        check({pfx, "_sel"}, sel, 0);
        check({pfx, "_wren"}, wren, 0);
        check({pfx, "_data"}, data, 0);
        check({pfx, "_filled"}, filled, 0);
        check({pfx, "_overrun"}, overrun, 0);
    endtask

    // Scoreboard and buffer model, evaluated on every falling clk edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                check("addr", addr, m_addr);
                check("sel", sel, m_sel);
                check("filled", filled, m_filled);
                check("overrun", overrun, m_over);
                exp_b = m_last;
                if (wren) begin
                    if (q.size() == 0) begin
                        check("wren_extra", wren, 0);
                    end else begin
                        exp_b = q.pop_front();
                        check("data", data, exp_b);
                    end
                end else begin
                    check("data_hold", data, m_last);
                end
                if (rst_rel) begin
                    rst_n   = 1'b1;
                    rst_rel = 1'b0;
                end
                cmpl = wren && (m_addr == MAXA);
                case (ack_mode)
                    1:       ack = cmpl;
                    2:       ack = ($urandom_range(0, 40) == 0);
                    default: ack = 1'b0;
                endcase
                if (rst_at_wrlo && wren && m_addr[0] == 1'b0) begin
                    rst_n       = 1'b0;
                    enable      = 1'b0;
                    cap         = 1'b0;
                    rst_at_wrlo = 1'b0;
                    rst_rel     = 1'b1;
                end
                if (cmpl) begin
                    if (!m_filled || ack) begin
                        m_sel    = ~m_sel;
                        m_filled = 1'b1;
                    end else begin
                        m_over = 1'b1;
                    end
                end else if (ack && m_filled) begin
                    m_filled = 1'b0;
                end
                if (wren) begin
                    m_addr = (m_addr + 1) % (MAXA + 1);
                    m_last = exp_b;
                end
                if (!enable && !wren) m_addr = 0;
                if (!rst_n) begin
                    m_addr   = 0;
                    m_sel    = 1'b0;
                    m_filled = 1'b0;
                    m_over   = 1'b0;
                    m_last   = 8'h00;
                    q.delete();
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; mono = 1'b0;
        bclk = 1'b0; lrck = 1'b0; dat = 1'b0; ack = 1'b0;
        m_addr = 0; m_sel = 1'b0; m_filled = 1'b0; m_over = 1'b0;
        m_last = 8'h00; mon_on = 1'b0; cap = 1'b0; ack_mode = 0;
        rst_at_wrlo = 1'b0; rst_rel = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Stereo: enable mid right slot, first write is next left sample.
        send_frame(16'($urandom), 16'($urandom), 0);
        send_frame(16'($urandom), 16'($urandom), 1);
        cap = 1'b1;
        send_frame(16'h1234, 16'hABCD, 0);
        repeat (7) send_frame(16'($urandom), 16'($urandom), 0);
        @(negedge clk);
        check("half1_sel", sel, 1);
        check("half1_filled", filled, 1);
        check("half1_overrun", overrun, 0);

        // Ack arriving on the completion clk.
        ack_mode = 1;
        repeat (8) send_frame(16'($urandom), 16'($urandom), 0);
        ack_mode = 0;
        @(negedge clk);
        check("ackcmp_sel", sel, 0);
        check("ackcmp_filled", filled, 1);
        check("ackcmp_overrun", overrun, 0);

        // No ack: overrun, same half rewritten from address 0.
        repeat (8) send_frame(16'($urandom), 16'($urandom), 0);
        @(negedge clk);
        check("ovr_overrun", overrun, 1);
        check("ovr_sel", sel, 0);
        check("ovr_filled", filled, 1);
        check("ovr_addr", addr, 0);

        // Random acks, including while nothing is filled.
        ack_mode = 2;
        repeat (12) send_frame(16'($urandom), 16'($urandom), 0);
        ack_mode = 0;

        // Enable dropped mid-SHIFT: partial half discarded.
        cap = 1'b0;
        send_frame(16'($urandom), 16'($urandom), 2);
        @(negedge clk);
        check("drop_addr", addr, 0);
        check("drop_wren", wren, 0);

        // Mono: only left bytes, one half after 2^AW/2 frames.
        pulse_reset();
        mono = 1'b1;
        send_frame(16'($urandom), 16'($urandom), 0);
        send_frame(16'($urandom), 16'($urandom), 1);
        cap = 1'b1;
        repeat (16) send_frame(16'h8001, 16'h7FFF, 0);
        @(negedge clk);
        check("mono_sel", sel, 1);
        check("mono_filled", filled, 1);
        check("mono_overrun", overrun, 0);
        check("mono_addr", addr, 0);

        // Reset right after WR_LO: no WR_HI strobe afterwards.
        mono        = 1'b0;
        rst_at_wrlo = 1'b1;
        send_frame(16'($urandom), 16'($urandom), 0);
        @(negedge clk);
        check("midwr_hit", rst_at_wrlo, 0);
        check_reset_values("midwr");
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
